// File: rtl/paddle_arbiter.sv
// Two-player paddle arbiter: grants one player at a time and turns digital
// left/right requests into a paced, accelerating 2-bit Gray quadrature stream.
module paddle_arbiter #(
    parameter int unsigned CLKDIV      = 5500,
    parameter int unsigned ACCEL_STEPS = 32,
    parameter int unsigned HOLD_TICKS  = 64
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic left0,
    input  logic right0,
    input  logic left1,
    input  logic right1,
    input  logic arb_mode,
    input  logic force_player,
    output logic enc_a,
    output logic enc_b,
    output logic owner_valid,
    output logic owner,
    output logic step
);

    localparam int unsigned DIV_W  = $clog2(CLKDIV);
    localparam int unsigned RUN_W  = $clog2(ACCEL_STEPS + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [DIV_W-1:0]  SLOW_M1  = DIV_W'(CLKDIV - 1);
    localparam logic [DIV_W-1:0]  FAST_M1  = DIV_W'((CLKDIV >> 2) - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(ACCEL_STEPS);
    localparam logic [HOLD_W-1:0] HOLD_M1  = HOLD_W'(HOLD_TICKS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]        state, state_n;
    logic [1:0]        phase, phase_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [RUN_W-1:0]  run_cnt, run_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              last_dir, dir_n;

    logic              req0, req1, own, cur, req_o, dir_o;
    logic [DIV_W-1:0]  lim_m1;
    logic              tick, step_now, dir_change;

    assign req0     = left0 ^ right0;
    assign req1     = left1 ^ right1;
    assign own      = (state != IDLE);
    assign cur      = (state == OWN1);
    assign req_o    = cur ? req1 : req0;
    assign dir_o    = cur ? right1 : right0;
    assign lim_m1   = (run_cnt >= RUN_MAX) ? FAST_M1 : SLOW_M1;
    assign tick     = own && (div_cnt == lim_m1);
    assign step_now = tick && req_o;
    assign dir_change = own && req_o && (dir_o != last_dir);

    assign enc_a = phase[1];
    assign enc_b = phase[0];

    // Next-state, divider, speed, hold and phase logic.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        run_n   = run_cnt;
        hold_n  = hold_cnt;
        dir_n   = last_dir;
        phase_n = phase;

        if (arb_mode) begin
            state_n = force_player ? OWN1 : OWN0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0)      state_n = OWN0;
                    else if (req1) state_n = OWN1;
                end
                OWN0, OWN1: begin
                    if (tick && !req_o && (hold_cnt == HOLD_M1)) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        if (own) begin
            // A speed change can leave div_cnt beyond the new limit: wrap silently.
            if (tick || (div_cnt > lim_m1)) div_n = '0;
            else                            div_n = div_cnt + DIV_W'(1);

            if (dir_change || (tick && !req_o)) run_n = '0;
            if (step_now && (run_n < RUN_MAX))  run_n = run_n + RUN_W'(1);

            if (req_o || arb_mode) hold_n = '0;
            else if (tick)         hold_n = hold_cnt + HOLD_W'(1);

            if (req_o) dir_n = dir_o;
        end

        if (step_now)
            phase_n = dir_o ? {phase[0], ~phase[1]} : {~phase[0], phase[1]};

        if ((state_n != state) || (state_n == IDLE)) begin
            div_n  = '0;
            run_n  = '0;
            hold_n = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 2'b00;
            div_cnt     <= '0;
            run_cnt     <= '0;
            hold_cnt    <= '0;
            last_dir    <= 1'b0;
            owner_valid <= 1'b0;
            owner       <= 1'b0;
            step        <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            div_cnt     <= div_n;
            run_cnt     <= run_n;
            hold_cnt    <= hold_n;
            last_dir    <= dir_n;
            owner_valid <= (state_n != IDLE);
            owner       <= (state_n == OWN1);
            step        <= step_now;
        end
    end

endmodule

// File: tb/tb_paddle_arbiter.sv
// Directed bench for paddle_arbiter with CLKDIV=8, ACCEL_STEPS=4, HOLD_TICKS=4.
module tb_paddle_arbiter;

    logic clk_sys = 1'b0;
    logic reset, left0, right0, left1, right1, arb_mode, force_player;
    logic enc_a, enc_b, owner_valid, owner, step;

    int vectors = 0;
    int miscompares = 0;

    paddle_arbiter #(.CLKDIV(8), .ACCEL_STEPS(4), .HOLD_TICKS(4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .left0(left0), .right0(right0), .left1(left1), .right1(right1),
        .arb_mode(arb_mode), .force_player(force_player),
        .enc_a(enc_a), .enc_b(enc_b),
        .owner_valid(owner_valid), .owner(owner), .step(step)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] enc, input logic ov,
                           input logic own, input logic stp);
        chk({tag, ".enc"},   32'({enc_a, enc_b}), 32'(enc));
        chk({tag, ".ov"},    32'(owner_valid),    32'(ov));
        chk({tag, ".owner"}, 32'(owner),          32'(own));
        chk({tag, ".step"},  32'(step),           32'(stp));
    endtask

    // Advance n cycles, expecting a step pulse only on cycle 'hit' (0 = never).
    task automatic adv(input int n, input int hit, input string tag);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_sys);
            chk(tag, 32'(step), 32'(i == hit));
        end
    endtask

    initial begin
        logic [1:0] fwd [4];
        fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;

        reset = 1'b1; left0 = 1'b0; right0 = 1'b1; left1 = 1'b0; right1 = 1'b0;
        arb_mode = 1'b0; force_player = 1'b0;

        // T1: reset held with a request present
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            chk_all("t1_reset", 2'b00, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b0;

        // T2: grant at cycle 1, steps every 8 cycles
        @(negedge clk_sys);
        chk_all("t2_grant", 2'b00, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            adv(8, 8, "t2_step");
            chk("t2_phase", 32'({enc_a, enc_b}), 32'(fwd[s]));
        end

        // T4: accelerated interval of 2 after 4 steps
        for (int s = 0; s < 4; s++) begin
            adv(2, 2, "t4_fast");
            chk("t4_phase", 32'({enc_a, enc_b}), 32'(fwd[s]));
        end
        right0 = 1'b0; left0 = 1'b1;
        adv(8, 8, "t4_rev");
        chk("t4_rev_phase", 32'({enc_a, enc_b}), 32'(2'b10));
        adv(8, 8, "t4_rev2");
        chk("t4_rev2_phase", 32'({enc_a, enc_b}), 32'(2'b11));

        // T5: both directions = no request; release after 4 idle ticks
        right0 = 1'b1;
        adv(31, 0, "t5_nostep");
        chk("t5_still_owned", 32'(owner_valid), 32'(1'b1));
        chk("t5_hold_cnt", 32'(dut.hold_cnt), 32'(3));
        @(negedge clk_sys);
        chk_all("t5_released", 2'b11, 1'b0, 1'b0, 1'b0);

        // T3: tie goes to player 0; player 1 waits for release
        left0 = 1'b0; right0 = 1'b0;
        left0 = 1'b1; right1 = 1'b1;
        @(negedge clk_sys);
        chk_all("t3_tie", 2'b11, 1'b1, 1'b0, 1'b0);
        adv(8, 8, "t3_p0step");
        chk("t3_p0phase", 32'({enc_a, enc_b}), 32'(2'b01));
        left0 = 1'b0;
        adv(31, 0, "t3_p1blocked");
        chk("t3_owner0", 32'(owner), 32'(1'b0));
        @(negedge clk_sys);
        chk_all("t3_idle", 2'b01, 1'b0, 1'b0, 1'b0);
        @(negedge clk_sys);
        chk_all("t3_own1", 2'b01, 1'b1, 1'b1, 1'b0);
        adv(8, 8, "t3_p1step");
        chk("t3_p1phase", 32'({enc_a, enc_b}), 32'(2'b11));

        // T6: forced owner switching, mode release, reset mid-run
        adv(3, 0, "t6_run");
        arb_mode = 1'b1; force_player = 1'b0;
        @(negedge clk_sys);
        chk_all("t6_force0", 2'b11, 1'b1, 1'b0, 1'b0);
        chk("t6_div0a", 32'(dut.div_cnt), 32'(0));
        force_player = 1'b1;
        @(negedge clk_sys);
        chk_all("t6_force1", 2'b11, 1'b1, 1'b1, 1'b0);
        chk("t6_div0b", 32'(dut.div_cnt), 32'(0));
        arb_mode = 1'b0;
        @(negedge clk_sys);
        chk("t6_keep_owner", 32'(owner), 32'(1'b1));
        chk("t6_div1", 32'(dut.div_cnt), 32'(1));
        adv(6, 0, "t6_prestep");
        reset = 1'b1;
        @(negedge clk_sys);
        chk_all("t6_reset", 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk_all("t6_regrant", 2'b00, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
